// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC register, memory request generation and a small {pc, instr} buffer feeding decode.
// Optional performance counters are compiled in when IFU_PERF_COUNTERS_EN is defined.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic                  imem_enable_read,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  imem_data_valid,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full;
    logic                  enq;
    logic                  deq;

    assign fifo_full        = (count == FULL_COUNT);
    assign imem_enable_read = !rst && !fifo_full;
    assign imem_address     = {2'b00, pc[ADDR_WIDTH-1:2]};

    // A redirect discards the memory response and makes any pop irrelevant, since the buffer is flushed.
    assign enq = imem_enable_read && imem_data_valid && !redirect_valid;
    assign deq = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (count != '0);
    assign instr_data  = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (enq) begin
            pc <= pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (enq) begin
            data_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]   <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    // Counters ignore redirects; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (enq) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (fifo_full) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a combinational instruction memory model.
// Perf counter checks are included when IFU_PERF_COUNTERS_EN is defined.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_enable_read;
    logic [31:0] imem_data;
    logic        imem_data_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    logic [31:0] mem [16];
    int total;
    int bad;

    instruction_fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0),
        .FIFO_DEPTH(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_address    (imem_address),
        .imem_enable_read(imem_enable_read),
        .imem_data       (imem_data),
        .imem_data_valid (imem_data_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc)
`ifdef IFU_PERF_COUNTERS_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_data = (imem_address < 32'd16) ? mem[imem_address[3:0]] : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic dv, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        rst             = r;
        imem_data_valid = dv;
        instr_ready     = rdy;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkHead(input string tag, input int word);
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
        checkOutput({tag, "_data"}, instr_data, mem[word]);
        checkOutput({tag, "_pc"}, instr_pc, 32'(word * 4));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mem[0] = 32'h3e800093;
        mem[1] = 32'h7d008113;
        mem[2] = 32'h014000ef;
        mem[3] = 32'h83018213;
        for (int i = 4; i < 16; i++) begin
            mem[i] = 32'ha000_0000 + 32'(i);
        end

        // Reset state
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_enable", 32'(imem_enable_read), 32'd0);
        checkOutput("rst_addr", imem_address, 32'h0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_data", instr_data, 32'h0);
        checkOutput("rst_pc", instr_pc, 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
        checkOutput("rst_perf_fetched", perf_fetched, 32'd0);
        checkOutput("rst_perf_stall", perf_stall_cycles, 32'd0);
`endif

        // Sequential fetch, one instruction per cycle
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("seq_c0_enable", 32'(imem_enable_read), 32'd1);
        checkOutput("seq_c0_addr", imem_address, 32'h0);
        checkOutput("seq_c0_valid", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkHead($sformatf("seq_head%0d", k), k);
            checkOutput($sformatf("seq_addr%0d", k), imem_address, 32'(k + 1));
        end

        // Backpressure: ready low for 10 cycles
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("bp_enable%0d", i), 32'(imem_enable_read), (i < 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("bp_addr%0d", i), imem_address, (i < 4) ? 32'(i) : 32'd4);
            if (i == 0) begin
                checkOutput("bp_valid0", 32'(instr_valid), 32'd0);
            end else begin
                checkHead($sformatf("bp_head%0d", i), 0);
            end
            tick();
        end
`ifdef IFU_PERF_COUNTERS_EN
        checkOutput("bp_perf_fetched", perf_fetched, 32'd4);
        checkOutput("bp_perf_stall", perf_stall_cycles, 32'd6);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            checkHead($sformatf("bp_drain%0d", k), k);
            tick();
        end

        // Memory wait on the PC 0x8 request
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("wait_addr%0d", i), imem_address, 32'h2);
            checkOutput($sformatf("wait_enable%0d", i), 32'(imem_enable_read), 32'd1);
            if (i == 0) begin
                checkHead("wait_head_w1", 1);
            end else begin
                checkOutput($sformatf("wait_valid%0d", i), 32'(instr_valid), 32'd0);
            end
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wait_resume_addr", imem_address, 32'h2);
        checkOutput("wait_resume_valid", 32'(instr_valid), 32'd0);
        tick();
        checkHead("wait_head_w2", 2);
        checkOutput("wait_addr_next", imem_address, 32'h3);
        tick();
        checkHead("wait_head_w3", 3);

        // Redirect while three entries are buffered and a response is valid
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        checkHead("redir_pre_head", 0);
        checkOutput("redir_pre_addr", imem_address, 32'h3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0006);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_valid", 32'(instr_valid), 32'd0);
        checkOutput("redir_addr", imem_address, 32'h1);
        checkOutput("redir_enable", 32'(imem_enable_read), 32'd1);
        tick();
        checkHead("redir_head_w1", 1);
        tick();
        checkHead("redir_head_w2", 2);

        // Reset with the buffer full
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("full_enable", 32'(imem_enable_read), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("midrst_enable", 32'(imem_enable_read), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("midrst_valid", 32'(instr_valid), 32'd0);
        checkOutput("midrst_addr", imem_address, 32'h0);
        checkOutput("midrst_data", instr_data, 32'h0);
        checkOutput("midrst_enable_after", 32'(imem_enable_read), 32'd1);
`ifdef IFU_PERF_COUNTERS_EN
        checkOutput("midrst_perf_fetched", perf_fetched, 32'd0);
        checkOutput("midrst_perf_stall", perf_stall_cycles, 32'd0);
`endif
        tick();
        checkHead("midrst_head_w0", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the core: owns the program counter, drives read requests into `instruction_memory`, and buffers returned instruction words with their PCs in a small FIFO for the decode stage. Decode is fed through a valid/ready handshake; execute can redirect fetch (branch/jump) with a single-cycle pulse, which flushes all buffered instructions.

## Interface
- `ADDR_WIDTH`, 32: PC and memory address width.
- `DATA_WIDTH`, 32: instruction word width.
- `RESET_PC`, 0: byte address fetched first after reset.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, ≥2.

- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_address`  out  ADDR_WIDTH: word address, `{2'b00, pc[ADDR_WIDTH-1:2]}`.
- `imem_enable_read`  out  1: read request.
- `imem_data`  in  DATA_WIDTH: instruction word from memory.
- `imem_data_valid`  in  1: `imem_data` valid this cycle.
- `redirect_valid`  in  1: one-cycle redirect pulse.
- `redirect_pc`  in  ADDR_WIDTH: redirect target, byte address.
- `instr_valid`  out  1: FIFO head valid.
- `instr_ready`  in  1: decode accepts head.
- `instr_data`  out  DATA_WIDTH: head instruction.
- `instr_pc`  out  ADDR_WIDTH: byte PC of head instruction.

## Operation
- State: `pc` register, FIFO storage of `{pc, instr}` entries, read/write pointers, `count` (width `$clog2(FIFO_DEPTH)+1`).
- Request: `imem_enable_read = !rst && (count != FIFO_DEPTH)`. Address is combinational from `pc`, held stable while no response arrives.
- Accept: when `imem_enable_read && imem_data_valid && !redirect_valid`, `{pc, imem_data}` is written at the tail and `pc <= pc + 4`. Without `imem_data_valid`, `pc` holds and the request repeats.
- Dequeue: `instr_valid && instr_ready` pops the head. Enqueue and dequeue in the same cycle leave `count` unchanged.
- Full: enable drops, so no enqueue occurs even if decode pops that cycle. Fetch resumes the following cycle.
- Empty: `instr_valid = 0`. `instr_data`/`instr_pc` are don't-care (storage resets to 0).
- Redirect has priority over everything:
  - FIFO flushed (`count <= 0`, pointers to 0).
  - `pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}`; bits [1:0] are ignored.
  - Memory response in that cycle is discarded.
  - A same-cycle decode handshake is honoured by decode, but the entry is gone anyway.
- Pointers wrap modulo `FIFO_DEPTH`. `pc` wraps modulo 2^ADDR_WIDTH.
- Reset values:
  - `pc = RESET_PC & ~3`, `count = 0`, pointers 0, storage 0.
  - `instr_valid = 0`, `instr_data = 0`, `instr_pc = 0`.
  - `imem_enable_read = 0` while `rst` is high. `imem_address` reflects the reset `pc`.
- Reset mid-operation: all of the above on the next edge. In-flight data is discarded.

## Timing
- Memory is read combinationally: a response can arrive in the same cycle as the request.
- Latency: word accepted on edge N is at the FIFO head (`instr_valid` high) in cycle N+1.
- First cycle after reset deasserts: request to `RESET_PC>>2`. First `instr_valid` one cycle later.
- Throughput: one instruction per cycle with memory always valid and decode always ready.
- Redirect on edge N: request to the new target in cycle N+1. First new `instr_valid` in cycle N+2.
- Handshake rule: while `instr_valid && !instr_ready`, the head and its PC stay stable.

## Configuration
- `IFU_PERF_COUNTERS_EN` defined: adds two outputs.
  - `perf_fetched` [31:0]: counts accepted enqueues.
  - `perf_stall_cycles` [31:0]: counts cycles with `!rst && count == FIFO_DEPTH`.
  - Both reset to 0, are cleared by `rst`, wrap at 2^32, and are unaffected by redirect.
- Not defined: ports and logic are absent. Functional behaviour is identical.

## Test plan
- Sequential fetch: memory image 0x3e800093, 0x7d008113, 0x014000ef, 0x83018213; data_valid tied high; instr_ready high -> four instructions at PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles; first `instr_valid` one cycle after reset release.
- Backpressure: instr_ready low for 10 cycles -> `imem_enable_read` drops after exactly 4 accepts; head stays 0x3e800093 @0x0; releasing ready drains in order, no loss or duplication.
- Memory wait: data_valid low for 3 cycles on the PC 0x8 request -> `imem_address` holds 0x2; `pc` holds; 0x014000ef @0x8 is enqueued once.
- Redirect: pulse with `redirect_pc = 0x0000_0006` while the FIFO holds 3 entries and a response is valid -> FIFO empties; next request address 0x1; next delivered PC is 0x4; the discarded response never appears.
- Reset mid-stream: `rst` asserted for 1 cycle with FIFO full -> `instr_valid` 0 next cycle; fetch restarts at `RESET_PC`.
- With `IFU_PERF_COUNTERS_EN`: the backpressure scenario yields `perf_fetched` = 4 and `perf_stall_cycles` = 6 before ready is released.
